alu_sliced: RTL and testbench

Parametrised multi-cycle successor to the 64-bit ripple ALU: computes a WIDTH-bit AND/OR/ADD/SUB/NOR by processing SLICE_W bits per clock, carrying between slices in a register. The datapath stays short, so it can be timed at high clock rates. It adds a valid/ready handshake and Zero/Overflow flags. It sits between the register-read stage and writeback in the multi-cycle core.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_sliced_if.sv | 30 +++
 rtl/alu_slice.sv | 49 ++++
 rtl/alu_sliced.sv | 116 +++++++++++
 tb/tb_alu_sliced.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sliced multi-cycle ALU.
//   - ALUOp encodings (AND, OR, ADD, SUB, NOR)
//   - FSM state type for the slice sequencer
//   - is_arith(): true for the ops that carry between slices and set flags
package alu_pkg;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_NOR = 4'b1100;

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DONE
   } state_e;

   function automatic logic is_arith(input logic [3:0] op);
      return (op == ALU_ADD) || (op == ALU_SUB);
   endfunction

endpackage

// File: rtl/alu_sliced_if.sv
// alu_sliced_if: request/response bundle of the sliced ALU.
//   Request : start_valid/start_ready, a, b, ALUOp, CarryIn
//   Response: result_valid/result_ready, Result, CarryOut, Zero, Overflow
//   master = requester/consumer side, slave = ALU side.
interface alu_sliced_if #(
   parameter int WIDTH = 64
);
   logic             start_valid;
   logic             start_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [3:0]       ALUOp;
   logic             CarryIn;
   logic             result_valid;
   logic             result_ready;
   logic [WIDTH-1:0] Result;
   logic             CarryOut;
   logic             Zero;
   logic             Overflow;

   modport master (
      output start_valid, a, b, ALUOp, CarryIn, result_ready,
      input  start_ready, result_valid, Result, CarryOut, Zero, Overflow
   );

   modport slave (
      input  start_valid, a, b, ALUOp, CarryIn, result_ready,
      output start_ready, result_valid, Result, CarryOut, Zero, Overflow
   );
endinterface

// File: rtl/alu_slice.sv
// alu_slice: combinational SLICE_W-bit ALU slice.
//   a_i, b_i : operand slices
//   op_i     : ALUOp
//   cin_i    : carry into bit 0 of the slice
//   res_o    : slice result (0 for unknown ops)
//   cout_o   : carry out of the slice (0 for logic/unknown ops)
//   cmsb_o   : carry into the slice MSB, used for signed overflow
module alu_slice
   import alu_pkg::*;
#(
   parameter int SLICE_W = 8
) (
   input  logic [SLICE_W-1:0] a_i,
   input  logic [SLICE_W-1:0] b_i,
   input  logic [3:0]         op_i,
   input  logic               cin_i,
   output logic [SLICE_W-1:0] res_o,
   output logic               cout_o,
   output logic               cmsb_o
);

   logic [SLICE_W-1:0] b_eff;
   logic [SLICE_W:0]   sum;

   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves
      // a signal unassigned, which would otherwise infer a latch.
      res_o  = '0;
      cout_o = 1'b0;
      cmsb_o = 1'b0;
      // SUB is a + ~b with the +1 arriving as the initial carry.
      b_eff  = (op_i == ALU_SUB) ? ~b_i : b_i;
      sum    = {1'b0, a_i} + {1'b0, b_eff} + {{SLICE_W{1'b0}}, cin_i};
      case (op_i)
         ALU_AND: res_o = a_i & b_i;
         ALU_OR:  res_o = a_i | b_i;
         ALU_NOR: res_o = ~(a_i | b_i);
         ALU_ADD, ALU_SUB: begin
            res_o  = sum[SLICE_W-1:0];
            cout_o = sum[SLICE_W];
            // Sum bit = a ^ b ^ carry-in, so the carry into the MSB falls out
            // of the MSB bits without a second adder.
            cmsb_o = sum[SLICE_W-1] ^ a_i[SLICE_W-1] ^ b_eff[SLICE_W-1];
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/alu_sliced.sv
// alu_sliced: multi-cycle WIDTH-bit ALU processing SLICE_W bits per clock.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset, aborts any operation in flight
//   bus   : alu_sliced_if.slave (request handshake, operands, result, flags)
// One alu_slice is shared across all slices; the inter-slice carry is a
// register, so the critical path is a single SLICE_W-bit ripple.
// WIDTH must be a multiple of SLICE_W.
module alu_sliced
   import alu_pkg::*;
#(
   parameter int WIDTH   = 64,
   parameter int SLICE_W = 8
) (
   input logic         clk,
   input logic         reset,
   alu_sliced_if.slave bus
);

   localparam int N     = WIDTH / SLICE_W;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

   state_e             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [3:0]         op_q;
   logic               carry_q;
   logic [WIDTH-1:0]   result_q;
   logic               carry_out_q;
   logic               zero_q;
   logic               overflow_q;

   logic [IDX_W-1:0]   base;
   logic [SLICE_W-1:0] sl_a;
   logic [SLICE_W-1:0] sl_b;
   logic [SLICE_W-1:0] sl_res;
   logic               sl_cout;
   logic               sl_cmsb;

   // Bit offset of the active slice. When N == 1 the counter is always 0, so
   // truncating SLICE_W into IDX_W bits cannot change the product.
   always_comb begin
      base = IDX_W'(cnt_q) * IDX_W'(SLICE_W);
      sl_a = a_q[base +: SLICE_W];
      sl_b = b_q[base +: SLICE_W];
   end

   alu_slice #(.SLICE_W(SLICE_W)) u_slice (
      .a_i    (sl_a),
      .b_i    (sl_b),
      .op_i   (op_q),
      .cin_i  (carry_q),
      .res_o  (sl_res),
      .cout_o (sl_cout),
      .cmsb_o (sl_cmsb)
   );

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= ALU_AND;
         carry_q     <= 1'b0;
         result_q    <= '0;
         carry_out_q <= 1'b0;
         zero_q      <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.start_valid) begin
                  a_q     <= bus.a;
                  b_q     <= bus.b;
                  op_q    <= bus.ALUOp;
                  carry_q <= (bus.ALUOp == ALU_ADD) ? bus.CarryIn
                                                    : (bus.ALUOp == ALU_SUB);
                  cnt_q   <= '0;
                  zero_q  <= 1'b1;
                  state_q <= S_BUSY;
               end
            end
            S_BUSY: begin
               result_q[base +: SLICE_W] <= sl_res;
               carry_q <= sl_cout;
               zero_q  <= zero_q & (sl_res == '0);
               if (cnt_q == CNT_LAST) begin
                  carry_out_q <= is_arith(op_q) & sl_cout;
                  overflow_q  <= is_arith(op_q) & (sl_cout ^ sl_cmsb);
                  cnt_q       <= '0;
                  state_q     <= S_DONE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_DONE: begin
               if (bus.result_ready) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.start_ready  = (state_q == S_IDLE);
   assign bus.result_valid = (state_q == S_DONE);
   assign bus.Result       = result_q;
   assign bus.CarryOut     = carry_out_q;
   assign bus.Zero         = zero_q;
   assign bus.Overflow     = overflow_q;

endmodule

// File: tb/tb_alu_sliced.sv
// tb_alu_sliced: scoreboard bench for alu_sliced.
//   dut64: WIDTH=64, SLICE_W=8 (N=8); dut16: WIDTH=16, SLICE_W=16 (N=1).
//   Expected results are pushed when a request is driven and popped when
//   result_valid is seen.
module tb_alu_sliced;
   import alu_pkg::*;

   typedef struct {
      logic [63:0] res;
      logic        cout;
      logic        zero;
      logic        ovf;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad = 0;
   exp_t sb64[$];
   exp_t sb16[$];

   alu_sliced_if #(.WIDTH(64)) bus64 ();
   alu_sliced_if #(.WIDTH(16)) bus16 ();

   alu_sliced #(.WIDTH(64), .SLICE_W(8)) dut64 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus64)
   );

   alu_sliced #(.WIDTH(16), .SLICE_W(16)) dut16 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus16)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   // Whole-word reference: wide arithmetic plus sign rules for overflow.
   function automatic exp_t model64(input logic [3:0] op, input logic [63:0] a,
                                    input logic [63:0] b, input logic cin);
      exp_t e;
      logic [64:0] s;
      e.res = '0; e.cout = 1'b0; e.ovf = 1'b0;
      case (op)
         ALU_AND: e.res = a & b;
         ALU_OR:  e.res = a | b;
         ALU_NOR: e.res = ~(a | b);
         ALU_ADD: begin
            s = {1'b0, a} + {1'b0, b} + {64'd0, cin};
            e.res = s[63:0]; e.cout = s[64];
            e.ovf = (a[63] == b[63]) && (s[63] != a[63]);
         end
         ALU_SUB: begin
            s = {1'b0, a} + {1'b0, ~b} + 65'd1;
            e.res = s[63:0]; e.cout = s[64];
            e.ovf = (a[63] != b[63]) && (s[63] != a[63]);
         end
         default: ;
      endcase
      e.zero = (e.res == 64'd0);
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue64(input logic [3:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic cin);
      int w = 0;
      while (!bus64.start_ready && w < 50) begin tick(); w++; end
      total++;
      if (!bus64.start_ready) begin
         bad++;
         $display("FAIL issue64_timeout start_ready=%0b required=1", bus64.start_ready);
      end
      bus64.start_valid = 1'b1;
      bus64.ALUOp = op; bus64.a = a; bus64.b = b; bus64.CarryIn = cin;
      sb64.push_back(model64(op, a, b, cin));
      tick();
      // Scramble the request so a late operand sample would show up.
      bus64.start_valid = 1'b0;
      bus64.a = {$urandom, $urandom};
      bus64.b = {$urandom, $urandom};
      bus64.ALUOp = 4'($urandom);
      bus64.CarryIn = 1'($urandom);
   endtask

   task automatic wait64(output int lat);
      lat = 0;
      while (!bus64.result_valid && lat < 50) begin tick(); lat++; end
   endtask

   task automatic consume64();
      bus64.result_ready = 1'b1;
      tick();
      bus64.result_ready = 1'b0;
   endtask

   // Issue one op on dut64, wait for it and compare against the scoreboard.
   task automatic run64(input string name, input logic [3:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic cin);
      int   lat;
      exp_t e;
      issue64(op, a, b, cin);
      wait64(lat);
      e = sb64.pop_front();
      total++;
      if (lat != 8) begin
         bad++; $display("FAIL %s_latency got=%0d want=8", name, lat);
      end
      total++;
      if (bus64.Result !== e.res) begin
         bad++; $display("FAIL %s_result got=%h want=%h", name, bus64.Result, e.res);
      end
      total++;
      if ({bus64.CarryOut, bus64.Zero, bus64.Overflow} !== {e.cout, e.zero, e.ovf}) begin
         bad++;
         $display("FAIL %s_flags c/z/v got=%b%b%b want=%b%b%b", name, bus64.CarryOut,
                  bus64.Zero, bus64.Overflow, e.cout, e.zero, e.ovf);
      end
      consume64();
   endtask

   task automatic test_reset();
      total++;
      if ({bus64.start_ready, bus64.result_valid, bus64.CarryOut, bus64.Zero, bus64.Overflow}
          !== 5'b10000 || bus64.Result !== 64'd0) begin
         bad++;
         $display("FAIL reset_values rdy/vld/c/z/v got=%b%b%b%b%b res=%h want=10000 res=0",
                  bus64.start_ready, bus64.result_valid, bus64.CarryOut, bus64.Zero,
                  bus64.Overflow, bus64.Result);
      end
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic test_add_wrap();
      run64("add_wrap", ALU_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
   endtask

   task automatic test_sub();
      run64("sub_cin0", ALU_SUB, 64'd5, 64'd7, 1'b0);
      run64("sub_cin1", ALU_SUB, 64'd5, 64'd7, 1'b1);
   endtask

   task automatic test_add_ovf();
      run64("add_ovf", ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
   endtask

   task automatic test_mixed();
      logic [3:0] ops [7] = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_NOR, 4'b0101, ALU_SUB};
      for (int i = 0; i < 7; i++)
         run64($sformatf("mix%0d", i), ops[i], {$urandom, $urandom}, {$urandom, $urandom},
               1'($urandom));
      run64("sub_equal", ALU_SUB, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
      run64("sub_ovf", ALU_SUB, 64'h8000_0000_0000_0000, 64'd1, 1'b0);
      run64("add_cin", ALU_ADD, 64'h0000_00FF_0000_00FF, 64'h0000_0001_0000_0000, 1'b1);
   endtask

   task automatic test_backpressure();
      int   lat;
      exp_t e;
      issue64(ALU_ADD, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1);
      wait64(lat);
      e = sb64.pop_front();
      for (int i = 0; i < 5; i++) begin
         bus64.start_valid = 1'b1;
         bus64.ALUOp = ALU_OR; bus64.a = 64'hAAAA; bus64.b = 64'h5555; bus64.CarryIn = 1'b0;
         tick();
         total++;
         if (!(bus64.result_valid === 1'b1 && bus64.start_ready === 1'b0 &&
               bus64.Result === e.res &&
               {bus64.CarryOut, bus64.Zero, bus64.Overflow} === {e.cout, e.zero, e.ovf})) begin
            bad++;
            $display("FAIL hold%0d vld=%b rdy=%b res=%h cv=%b%b%b want vld=1 rdy=0 res=%h cv=%b%b%b",
                     i, bus64.result_valid, bus64.start_ready, bus64.Result, bus64.CarryOut,
                     bus64.Zero, bus64.Overflow, e.res, e.cout, e.zero, e.ovf);
         end
      end
      bus64.start_valid = 1'b0;
      consume64();
      total++;
      if ({bus64.start_ready, bus64.result_valid} !== 2'b10) begin
         bad++;
         $display("FAIL release rdy/vld got=%b%b want=10", bus64.start_ready, bus64.result_valid);
      end
   endtask

   task automatic test_reset_abort();
      issue64(ALU_ADD, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 1'b0);
      tick(); tick(); tick();
      reset = 1'b1;
      #1;
      void'(sb64.pop_front());
      total++;
      if ({bus64.start_ready, bus64.result_valid, bus64.CarryOut, bus64.Zero, bus64.Overflow}
          !== 5'b10000 || bus64.Result !== 64'd0) begin
         bad++;
         $display("FAIL abort_values rdy/vld/c/z/v got=%b%b%b%b%b res=%h want=10000 res=0",
                  bus64.start_ready, bus64.result_valid, bus64.CarryOut, bus64.Zero,
                  bus64.Overflow, bus64.Result);
      end
      tick();
      reset = 1'b0;
      run64("and_after_reset", ALU_AND, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 1'b0);
   endtask

   task automatic run16(input string name, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b);
      int   lat = 0;
      exp_t e;
      bus16.start_valid = 1'b1;
      bus16.ALUOp = op; bus16.a = a; bus16.b = b; bus16.CarryIn = 1'b0;
      tick();
      bus16.start_valid = 1'b0;
      bus16.a = 16'($urandom); bus16.b = 16'($urandom);
      while (!bus16.result_valid && lat < 50) begin tick(); lat++; end
      e = sb16.pop_front();
      total++;
      if (lat != 1 || bus16.Result !== e.res[15:0] || bus16.Zero !== e.zero) begin
         bad++;
         $display("FAIL %s lat=%0d res=%h z=%b want lat=1 res=%h z=%b", name, lat,
                  bus16.Result, bus16.Zero, e.res[15:0], e.zero);
      end
      bus16.result_ready = 1'b1;
      tick();
      bus16.result_ready = 1'b0;
   endtask

   task automatic test_narrow();
      sb16.push_back('{res: 64'h0000_0000_0000_FFFF, cout: 1'b0, zero: 1'b0, ovf: 1'b0});
      run16("n16_nor", ALU_NOR, 16'h0000, 16'h0000);
      sb16.push_back('{res: 64'd0, cout: 1'b0, zero: 1'b1, ovf: 1'b0});
      run16("n16_illegal", 4'b1111, 16'h1234, 16'hABCD);
   endtask

   initial begin
      bus64.start_valid = 1'b0; bus64.result_ready = 1'b0;
      bus64.a = '0; bus64.b = '0; bus64.ALUOp = '0; bus64.CarryIn = 1'b0;
      bus16.start_valid = 1'b0; bus16.result_ready = 1'b0;
      bus16.a = '0; bus16.b = '0; bus16.ALUOp = '0; bus16.CarryIn = 1'b0;
      #12;
      test_reset();
      test_add_wrap();
      test_sub();
      test_add_ovf();
      test_mixed();
      test_backpressure();
      test_reset_abort();
      test_narrow();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
